// File: rtl/fantasy_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fantasy_pkg
//  Purpose  : Shared 1080p raster constants, controller state encoding and
//             small sizing helpers used by the input cursor and the output
//             timing generator.
//  Revision : 1.0 - initial release
// ============================================================================
package fantasy_pkg;

  // 1920x1080 @ 148.5 MHz pixel clock raster
  localparam int c_FHD_H_WIDTH  = 1920;
  localparam int c_FHD_H_START  = 2008;
  localparam int c_FHD_H_SYNC   = 44;
  localparam int c_FHD_H_TOTAL  = 2200;
  localparam int c_FHD_V_HEIGHT = 1080;
  localparam int c_FHD_V_START  = 1084;
  localparam int c_FHD_V_SYNC   = 5;
  localparam int c_FHD_V_TOTAL  = 1125;
  localparam int c_FHD_KH       = 30;
  localparam int c_FHD_KV       = 30;

  // Raster controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } vtg_state_t;

  // Width of a counter holding 0..n-1; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Number of horizontal blocks in a line, counting a partial last block
  function automatic int hblks(input int h_width, input int kh);
    return (h_width + kh - 1) / kh;
  endfunction

  // Number of block rows in a frame, counting a partial last row
  function automatic int vblks(input int v_height, input int kv);
    return (v_height + kv - 1) / kv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blk_counter.sv
`default_nettype none
// ============================================================================
//  Module   : blk_counter
//  Purpose  : Wrapping index counter 0..N-1 for block tiling. Advances on
//             i_step, returns to zero on i_clear, flags the last index.
//  Revision : 1.0 - initial release
// ============================================================================
module blk_counter #(
  parameter int N = 30,
  parameter int W = (N <= 2) ? 1 : $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_step,
  input  logic         i_clear,
  output logic [W-1:0] o_idx,
  output logic         o_last
);

  localparam logic [W-1:0] c_LAST = W'(N - 1);

  logic [W-1:0] r_idx;

  // Index register: clear wins over step so a line/frame boundary always restarts at 0
  always_ff @(posedge clk_i) begin
    if (rst_i || i_clear) begin
      r_idx <= '0;
    end else if (i_step) begin
      r_idx <= (r_idx == c_LAST) ? '0 : r_idx + W'(1);
    end
  end

  assign o_idx  = r_idx;
  assign o_last = (r_idx == c_LAST);

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : video_timing_gen
//  Purpose  : Creates raster timing (hs/vs/de), pixel coordinates and block
//             save pulses from free-running position counters, and registers
//             pixel data onto that raster. Every output is a flop lagging the
//             counter position by one clock.
//  Revision : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import fantasy_pkg::*;
#(
  parameter int H_WIDTH  = c_FHD_H_WIDTH,
  parameter int H_START  = c_FHD_H_START,
  parameter int H_SYNC   = c_FHD_H_SYNC,
  parameter int H_TOTAL  = c_FHD_H_TOTAL,
  parameter int V_HEIGHT = c_FHD_V_HEIGHT,
  parameter int V_START  = c_FHD_V_START,
  parameter int V_SYNC   = c_FHD_V_SYNC,
  parameter int V_TOTAL  = c_FHD_V_TOTAL,
  parameter int KH       = c_FHD_KH,
  parameter int KV       = c_FHD_KV,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic [23:0]                data_i,
  output logic                       hs_o,
  output logic                       vs_o,
  output logic                       de_o,
  output logic [$clog2(H_TOTAL)-1:0] x_o,
  output logic [$clog2(V_TOTAL)-1:0] y_o,
  output logic                       h_save_o,
  output logic                       v_save_o,
  output logic                       frame_o,
  output logic [23:0]                data_o,
  output logic                       busy_o
);

  localparam int c_HW  = $clog2(H_TOTAL);
  localparam int c_VW  = $clog2(V_TOTAL);
  localparam int c_KXW = cnt_width(KH);
  localparam int c_KYW = cnt_width(KV);

  // Sync pulses must fit inside the line / frame
  if ((H_START + H_SYNC > H_TOTAL) || (V_START + V_SYNC > V_TOTAL)) begin : g_param_check
    $error("video_timing_gen: sync pulse extends past H_TOTAL or V_TOTAL");
  end

  vtg_state_t       r_state;
  logic [c_HW-1:0]  r_hc;
  logic [c_VW-1:0]  r_vc;

  logic [31:0]      w_hcx;
  logic [31:0]      w_vcx;
  logic             w_active;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_frame_end;
  logic             w_de;
  logic             w_hs_act;
  logic             w_vs_act;
  logic             w_hs_lead;
  logic             w_h_act_end;
  logic             w_v_act_last;
  logic [c_HW-1:0]  w_hc_next;
  logic [c_VW-1:0]  w_vc_next;

  logic [c_KXW-1:0] w_kx;
  logic [c_KYW-1:0] w_ky;
  logic             w_kx_last;
  logic             w_ky_last;
  logic             w_kx_clear;
  logic             w_ky_step;
  logic             w_ky_clear;
  logic             w_unused_idx;

  // Decode the current counter position into raster regions and next position
  always_comb begin
    w_hcx        = 32'(r_hc);
    w_vcx        = 32'(r_vc);
    w_active     = (r_state != ST_IDLE);
    w_h_last     = (w_hcx == H_TOTAL - 1);
    w_v_last     = (w_vcx == V_TOTAL - 1);
    w_frame_end  = w_h_last && w_v_last;
    w_de         = (w_hcx < H_WIDTH) && (w_vcx < V_HEIGHT);
    w_hs_act     = (w_hcx >= H_START) && (w_hcx < H_START + H_SYNC);
    w_vs_act     = (w_vcx >= V_START) && (w_vcx < V_START + V_SYNC);
    w_hs_lead    = (w_hcx == H_START);
    w_h_act_end  = (w_hcx == H_WIDTH - 1);
    w_v_act_last = (w_vcx == V_HEIGHT - 1);
    w_hc_next    = w_h_last ? '0 : r_hc + c_HW'(1);
    w_vc_next    = r_vc;
    if (w_h_last) begin
      w_vc_next = w_v_last ? '0 : r_vc + c_VW'(1);
    end
  end

  // Block tiling controls: kx restarts every line, ky restarts after the last active line
  always_comb begin
    w_kx_clear = !w_active || w_h_act_end;
    w_ky_step  = w_de && w_h_act_end;
    w_ky_clear = !w_active || (w_h_act_end && w_v_act_last);
  end

  blk_counter #(
    .N (KH),
    .W (c_KXW)
  ) u_blk_h (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_step  (w_de),
    .i_clear (w_kx_clear),
    .o_idx   (w_kx),
    .o_last  (w_kx_last)
  );

  blk_counter #(
    .N (KV),
    .W (c_KYW)
  ) u_blk_v (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_step  (w_ky_step),
    .i_clear (w_ky_clear),
    .o_idx   (w_ky),
    .o_last  (w_ky_last)
  );

  // Block indices are not needed at the ports; only the last flags drive the save pulses
  assign w_unused_idx = ^{w_kx, w_ky};

  // Run-control FSM, position counters and registered raster outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_hc     <= '0;
      r_vc     <= '0;
      hs_o     <= ~HS_POL;
      vs_o     <= ~VS_POL;
      de_o     <= 1'b0;
      x_o      <= '0;
      y_o      <= '0;
      h_save_o <= 1'b0;
      v_save_o <= 1'b0;
      frame_o  <= 1'b0;
      data_o   <= '0;
      busy_o   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (en_i) r_state <= ST_RUN;
        ST_RUN:  if (!en_i) r_state <= ST_STOP;
        ST_STOP: begin
          // A stopping run always finishes its frame before going idle
          if (en_i) begin
            r_state <= ST_RUN;
          end else if (w_frame_end) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_active) begin
        r_hc     <= w_hc_next;
        r_vc     <= w_vc_next;
        hs_o     <= w_hs_act ? HS_POL : ~HS_POL;
        // vsync edges are aligned to the hsync leading edge
        if (w_hs_lead) begin
          vs_o <= w_vs_act ? VS_POL : ~VS_POL;
        end
        de_o     <= w_de;
        x_o      <= r_hc;
        y_o      <= r_vc;
        h_save_o <= w_de && (w_kx_last || w_h_act_end);
        v_save_o <= w_de && w_h_act_end && (w_ky_last || w_v_act_last);
        frame_o  <= (r_hc == '0) && (r_vc == '0);
        data_o   <= w_de ? data_i : '0;
        busy_o   <= 1'b1;
      end else begin
        r_hc     <= '0;
        r_vc     <= '0;
        hs_o     <= ~HS_POL;
        vs_o     <= ~VS_POL;
        de_o     <= 1'b0;
        x_o      <= '0;
        y_o      <= '0;
        h_save_o <= 1'b0;
        v_save_o <= 1'b0;
        frame_o  <= 1'b0;
        data_o   <= '0;
        busy_o   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_video_timing_gen
//  Purpose  : Directed self-checking bench for video_timing_gen on a small
//             14x7 raster with 3x3 blocks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  localparam int NPOS = 14 * 7;

  logic        clk    = 1'b0;
  logic        rst_i  = 1'b1;
  logic        en_i   = 1'b0;
  logic [23:0] data_i = '0;
  logic        hs_o, vs_o, de_o, h_save_o, v_save_o, frame_o, busy_o;
  logic [3:0]  x_o;
  logic [2:0]  y_o;
  logic [23:0] data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_WIDTH (8),  .H_START (10), .H_SYNC (2), .H_TOTAL (14),
    .V_HEIGHT(4),  .V_START (5),  .V_SYNC (1), .V_TOTAL (7),
    .KH      (3),  .KV      (3),  .HS_POL (1'b1), .VS_POL (1'b1)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .en_i    (en_i),
    .data_i  (data_i),
    .hs_o    (hs_o),
    .vs_o    (vs_o),
    .de_o    (de_o),
    .x_o     (x_o),
    .y_o     (y_o),
    .h_save_o(h_save_o),
    .v_save_o(v_save_o),
    .frame_o (frame_o),
    .data_o  (data_o),
    .busy_o  (busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i  = 1'b1;
    en_i   = 1'b0;
    data_i = 24'hA5A5A5;
    tick();
    tick();
    rst_i  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    checks++; if (hs_o !== 1'b0) begin errors++; $display("FAIL reset_hs got %0b want 0", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset_vs got %0b want 0", vs_o); end
    checks++;
    if ({de_o, h_save_o, v_save_o, frame_o, x_o, y_o, data_o} !== '0) begin
      errors++;
      $display("FAIL reset_zero got de=%0b hs=%0b vs=%0b fr=%0b x=%0d y=%0d d=%h want all 0",
               de_o, h_save_o, v_save_o, frame_o, x_o, y_o, data_o);
    end
  endtask

  task automatic test_start();
    do_reset();
    en_i = 1'b1;
    tick();
    checks++; if ({de_o, frame_o, busy_o} !== 3'b000) begin errors++; $display("FAIL start_k got de/fr/busy=%b want 000", {de_o, frame_o, busy_o}); end
    tick();
    checks++; if ({de_o, frame_o, busy_o} !== 3'b111) begin errors++; $display("FAIL start_k1 got de/fr/busy=%b want 111", {de_o, frame_o, busy_o}); end
    checks++; if ({x_o, y_o} !== 7'd0) begin errors++; $display("FAIL start_xy got x=%0d y=%0d want 0 0", x_o, y_o); end
  endtask

  task automatic test_one_frame();
    int nde = 0, nfr = 0, nhs = 0;
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n < NPOS; n++) begin
      int hc = n % 14;
      int vc = n / 14;
      logic exp_de = (hc < 8) && (vc < 4);
      logic exp_hs = (hc == 10) || (hc == 11);
      tick();
      checks++; if (x_o !== 4'(hc) || y_o !== 3'(vc)) begin errors++; $display("FAIL frame_xy n=%0d got %0d,%0d want %0d,%0d", n, x_o, y_o, hc, vc); end
      checks++; if (de_o !== exp_de) begin errors++; $display("FAIL frame_de n=%0d got %0b want %0b", n, de_o, exp_de); end
      checks++; if (hs_o !== exp_hs) begin errors++; $display("FAIL frame_hs n=%0d got %0b want %0b", n, hs_o, exp_hs); end
      nde += int'(de_o);
      nfr += int'(frame_o);
      nhs += int'(hs_o);
    end
    checks++; if (nde != 32) begin errors++; $display("FAIL frame_de_count got %0d want 32", nde); end
    checks++; if (nfr != 1) begin errors++; $display("FAIL frame_pulse_count got %0d want 1", nfr); end
    checks++; if (nhs != 14) begin errors++; $display("FAIL frame_hs_count got %0d want 14", nhs); end
  endtask

  task automatic test_block_pulses();
    int nh = 0, nh2 = 0, nv = 0;
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n < NPOS; n++) begin
      int hc = n % 14;
      int vc = n / 14;
      logic de = (hc < 8) && (vc < 4);
      logic exp_h = de && (hc == 2 || hc == 5 || hc == 7);
      logic exp_v = de && (hc == 7) && (vc == 2 || vc == 3);
      tick();
      checks++; if (h_save_o !== exp_h) begin errors++; $display("FAIL h_save n=%0d got %0b want %0b", n, h_save_o, exp_h); end
      checks++; if (v_save_o !== exp_v) begin errors++; $display("FAIL v_save n=%0d got %0b want %0b", n, v_save_o, exp_v); end
      nh += int'(h_save_o);
      nv += int'(v_save_o);
      if (vc < 2) nh2 += int'(h_save_o);
    end
    checks++; if (nh2 != 6) begin errors++; $display("FAIL h_save_2lines got %0d want 6", nh2); end
    checks++; if (nh != 12) begin errors++; $display("FAIL h_save_frame got %0d want 12", nh); end
    checks++; if (nv != 2) begin errors++; $display("FAIL v_save_frame got %0d want 2", nv); end
  endtask

  task automatic test_vsync_back_to_back();
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n < 2 * NPOS; n++) begin
      int hc = n % 14;
      int vc = (n / 14) % 7;
      logic exp_vs = (vc == 5 && hc >= 10) || (vc == 6 && hc < 10);
      logic exp_fr = (hc == 0) && (vc == 0);
      tick();
      checks++; if (vs_o !== exp_vs) begin errors++; $display("FAIL vsync n=%0d x=%0d y=%0d got %0b want %0b", n, x_o, y_o, vs_o, exp_vs); end
      checks++; if (frame_o !== exp_fr) begin errors++; $display("FAIL frame_b2b n=%0d got %0b want %0b", n, frame_o, exp_fr); end
    end
  endtask

  task automatic test_data();
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n < NPOS; n++) begin
      int hc = n % 14;
      int vc = n / 14;
      logic [23:0] exp_d;
      data_i = 24'(hc * 16 + vc);
      exp_d  = ((hc < 8) && (vc < 4)) ? 24'(hc * 16 + vc) : 24'd0;
      tick();
      checks++; if (data_o !== exp_d) begin errors++; $display("FAIL data n=%0d got %h want %h", n, data_o, exp_d); end
    end
    data_i = '0;
  endtask

  task automatic test_graceful_stop();
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n < NPOS; n++) begin
      int hc = n % 14;
      int vc = n / 14;
      logic exp_de = (hc < 8) && (vc < 4);
      en_i = (n < 14) || (n == 40);
      tick();
      checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL stop_busy n=%0d got %0b want 1", n, busy_o); end
      checks++; if (de_o !== exp_de || x_o !== 4'(hc) || y_o !== 3'(vc)) begin
        errors++; $display("FAIL stop_pos n=%0d got de=%0b x=%0d y=%0d want de=%0b x=%0d y=%0d", n, de_o, x_o, y_o, exp_de, hc, vc);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stop_idle_busy i=%0d got %0b want 0", i, busy_o); end
      checks++; if ({hs_o, vs_o, de_o, frame_o, x_o, y_o} !== '0) begin
        errors++; $display("FAIL stop_idle_out i=%0d got hs=%0b vs=%0b de=%0b fr=%0b x=%0d y=%0d want 0", i, hs_o, vs_o, de_o, frame_o, x_o, y_o);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    en_i = 1'b1;
    tick();
    for (int n = 0; n <= 32; n++) tick();
    checks++; if (x_o !== 4'd4 || y_o !== 3'd2) begin errors++; $display("FAIL midrst_pre got x=%0d y=%0d want 4 2", x_o, y_o); end
    rst_i = 1'b1;
    tick();
    checks++; if ({de_o, busy_o, x_o, y_o} !== '0) begin errors++; $display("FAIL midrst_out got de=%0b busy=%0b x=%0d y=%0d want 0", de_o, busy_o, x_o, y_o); end
    rst_i = 1'b0;
    tick();
    checks++; if ({frame_o, busy_o} !== 2'b00) begin errors++; $display("FAIL midrst_k got fr/busy=%b want 00", {frame_o, busy_o}); end
    tick();
    checks++; if ({frame_o, de_o, x_o, y_o} !== {2'b11, 7'd0}) begin errors++; $display("FAIL midrst_restart got fr=%0b de=%0b x=%0d y=%0d want 1 1 0 0", frame_o, de_o, x_o, y_o); end
    tick();
    checks++; if (x_o !== 4'd1 || y_o !== 3'd0) begin errors++; $display("FAIL midrst_next got x=%0d y=%0d want 1 0", x_o, y_o); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_one_frame();
    test_block_pulses();
    test_vsync_back_to_back();
    test_data();
    test_graceful_stop();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/video_timing_gen.md
# video_timing_gen

Generates raster timing (hs/vs/de) plus pixel and block coordinates for the HDMI output side, and registers pixel data onto that raster. It is the transmit-side counterpart of the input cursor: the cursor recovers position from incoming sync, and this block creates sync from position. It sits between the frame/pattern source and the HDMI transmitter, and also runs the test-pattern path when no input clock is present.

## Interface
- H_WIDTH, 1920, active pixels per line
- H_START, 2008, hc at which hsync asserts
- H_SYNC, 44, hsync width in pixels
- H_TOTAL, 2200, pixels per line
- V_HEIGHT, 1080, active lines
- V_START, 1084, vc at which vsync asserts
- V_SYNC, 5, vsync width in lines
- V_TOTAL, 1125, lines per frame
- KH, 30, block width in pixels
- KV, 30, block height in lines
- HS_POL / VS_POL, 1, sync active level
- clk_i  in  1  pixel clock; one clock for everything
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  run request
- data_i  in  24  pixel for the current counter position
- hs_o / vs_o / de_o  out  1  registered sync and data enable
- x_o  out  $clog2(H_TOTAL)  registered hc
- y_o  out  $clog2(V_TOTAL)  registered vc
- h_save_o  out  1  pulse on the last active pixel of each horizontal block
- v_save_o  out  1  pulse on the last active pixel of the last line of each block row
- frame_o  out  1  pulse with hc=0, vc=0
- data_o  out  24  data_i registered; 0 when not de
- busy_o  out  1  state ≠ IDLE

## Operation
- **States:**
  - IDLE → RUN when en_i = 1. Counters are at 0 on that edge.
  - RUN → STOP when en_i = 0.
  - STOP → RUN when en_i = 1. There is no gap.
  - STOP → IDLE on the edge where hc = H_TOTAL-1 and vc = V_TOTAL-1. The last frame always completes.
- **Counters:** hc wraps at H_TOTAL-1. vc increments on the hc wrap and wraps at V_TOTAL-1.
- **Active region:** de = (hc < H_WIDTH) && (vc < V_HEIGHT).
- **Horizontal sync:** hs is active for H_START ≤ hc < H_START+H_SYNC.
- **Vertical sync:** vs is active for V_START ≤ vc < V_START+V_SYNC. vs changes only when hc = H_START, aligned to the hsync leading edge.
- **Horizontal blocks:** kx counts 0..KH-1 during de and clears at end of line.
  - h_save fires when kx = KH-1 or hc = H_WIDTH-1, so a partial last block still fires.
- **Vertical blocks:** ky counts lines 0..KV-1 and advances at hc = H_WIDTH-1 on active lines.
  - v_save fires at hc = H_WIDTH-1 when ky = KV-1 or vc = V_HEIGHT-1.
- **IDLE and reset state:**
  - hs_o = ~HS_POL, vs_o = ~VS_POL.
  - de_o, h_save_o, v_save_o, frame_o, busy_o, x_o, y_o, data_o all 0.
  - Counters are held at 0.
- **Reset mid-frame:** takes effect on the next edge. Outputs return to the IDLE values on that edge, and a later run restarts at hc = 0, vc = 0.
- **Parameter rule:** H_START+H_SYNC ≤ H_TOTAL and V_START+V_SYNC ≤ V_TOTAL. An elaboration-time check fails otherwise.

## Timing
- Every output is a flop. All outputs lag the counter position by exactly 1 cycle.
- data_i is sampled on the same edge as the counter position it belongs to.
- **Start of run:** en_i is sampled high at edge k. de_o and frame_o are first high after edge k+1.
- **End of run:** en_i is dropped mid-frame. de_o continues until the frame completes, then busy_o falls one edge after the final position.
- **en_i toggling in STOP:** does not disturb the counters.

## Structure
- **Shared package (`fantasy_pkg`):** holds the 1080p timing constants and the functions for HBLKS/VBLKS and counter widths, so the cursor and this block share them.
- **Sub-module `blk_counter`:** instantiated twice (horizontal and vertical). It has a step input and a clear input, and outputs its index and a last flag.

## Test plan
All scenarios use the small raster H_WIDTH=8, H_START=10, H_SYNC=2, H_TOTAL=14, V_HEIGHT=4, V_START=5, V_SYNC=1, V_TOTAL=7, KH=KV=3.

1. **One frame:** pulse en_i, then hold it high for 98 cycles → exactly 32 de_o cycles, hs_o high at x_o = 10..11 on every line, frame_o once.
2. **Block pulses:** h_save_o at x_o = 2, 5, 7 on each active line; v_save_o at (7,2) and (7,3); 6 h_save pulses per 2 lines.
3. **Vertical sync alignment:** vs_o asserts at x_o=10, y_o=5 and deasserts at x_o=10, y_o=6.
4. **Graceful stop:** drop en_i at y_o=1 → de_o continues through y_o=3, busy_o falls after x_o=13, y_o=6, and outputs hold the IDLE values.
5. **Reset mid-run:** rst_i high at x_o=4, y_o=2 → next cycle de_o = 0 and x_o = 0; with en_i still high after rst_i falls, the run restarts with frame_o.
6. **Data path:** data_i = hc*16+vc → data_o equals that value one cycle later during de_o, and 0 elsewhere.
